uart_rx: RTL and testbench

Receive-side UART engine: samples the serial input line at 16x oversampling and recovers 7- or 8-bit frames with 1 or 2 stop bits, as selected by the shared `config_t` settings. Each completed frame is presented on a valid/ready byte interface to the receive buffer, which drives the `rxe` status flag. Framing errors and overruns are flagged as single-cycle pulses for the control/status logic.

---
 rtl/data_types_pkg.sv | 35 +++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_types_pkg.sv
// Shared UART types: byte and configuration records, receiver FSM states and
// helpers that turn the configuration into per-frame bit counts.
package data_types_pkg;

  localparam int UART_OVS = 16;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    logic [15:0] br_div;
    logic        word;
    logic        stop;
    logic        en;
  } config_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    ERROR = 3'd4,
    WAIT  = 3'd5
  } state_t;

  // Number of data bits N carried by a frame.
  function automatic logic [3:0] cfg_data_bits(input config_t c);
    return c.word ? 4'd8 : 4'd7;
  endfunction

  // Number of stop bits S terminating a frame.
  function automatic logic [1:0] cfg_stop_bits(input config_t c);
    return c.stop ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud prescaler: pulses tick_o once every div_i+1 clocks. The pulse is
// registered, so the first tick after a clear lands div_i+1 clocks later.
module uart_baud_gen #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic [DW-1:0] div_i,
  output logic          tick_o
);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Count up to the divider, wrap and raise the tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q >= div_i) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled line recovery of 7/8-bit frames with 1 or 2
// stop bits, delivered on a valid/ready byte interface with error pulses.
module uart_rx
  import data_types_pkg::*;
#(
  parameter int OVS = UART_OVS
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  config_t cfg_i,
  input  logic    rxd_i,
  output byte_t   rx_data_o,
  output logic    rx_valid_o,
  input  logic    rx_ready_i,
  output logic    frame_err_o,
  output logic    overrun_err_o,
  output logic    busy_o
);

  localparam int            SW       = $clog2(OVS);
  localparam logic [SW-1:0] SUB_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(OVS - 1);

  logic [1:0]    sync_q;
  logic          rxd_s;
  logic          tick_s;
  logic          bit_tick_s;
  logic          abort_s;
  logic          complete_s;

  state_t        state_q, state_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    nbits_q, nbits_d;
  logic [1:0]    nstop_q, nstop_d;
  byte_t         shift_q, shift_d;
  byte_t         rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  assign rxd_s      = sync_q[1];
  assign bit_tick_s = tick_s && (sub_q == SUB_LAST);
  assign abort_s    = (state_q != IDLE) && !cfg_i.en;

  uart_baud_gen #(
    .DW (16)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q == IDLE),
    .div_i  (cfg_i.br_div),
    .tick_o (tick_s)
  );

  // Frame FSM: next state, oversample/bit counters and the data shifter.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    cnt_d       = cnt_q;
    nbits_d     = nbits_q;
    nstop_d     = nstop_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    complete_s  = 1'b0;

    if (tick_s) begin
      sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SW'(1);
    end else begin
      sub_d = sub_q;
    end

    if (abort_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          sub_d = '0;
          cnt_d = 4'd0;
          if (cfg_i.en && !rxd_s) begin
            state_d = START;
            nbits_d = cfg_data_bits(cfg_i);
            nstop_d = cfg_stop_bits(cfg_i);
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (tick_s && (sub_q == SUB_MID)) begin
            sub_d   = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (bit_tick_s) begin
            shift_d = {rxd_s, shift_q[7:1]};
            if (cnt_q == nbits_q - 4'd1) begin
              state_d = STOP;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = DATA;
          end
        end
        STOP: begin
          if (bit_tick_s) begin
            if (!rxd_s) begin
              state_d     = ERROR;
              frame_err_d = 1'b1;
            end else if (cnt_q == {2'b00, nstop_q} - 4'd1) begin
              // Leave mid-stop-bit so a following start edge is not missed.
              state_d    = IDLE;
              complete_s = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = STOP;
          end
        end
        ERROR: begin
          state_d = WAIT;
        end
        WAIT: begin
          state_d = rxd_s ? IDLE : WAIT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output byte buffer: load on completion when free or freed this cycle.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (complete_s && (!rx_valid_q || rx_ready_i)) begin
      rx_data_d  = (nbits_q == 4'd8) ? shift_q : {1'b0, shift_q[7:1]};
      rx_valid_d = 1'b1;
    end else if (complete_s) begin
      overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      sub_q       <= '0;
      cnt_q       <= 4'd0;
      nbits_q     <= 4'd8;
      nstop_q     <= 2'd1;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd_i};
      state_q     <= state_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      nbits_q     <= nbits_d;
      nstop_q     <= nstop_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: frame formats, latency, glitch,
// framing error, overrun, same-cycle accept, abort and mid-frame reset.
module tb_uart_rx;
  import data_types_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  config_t cfg;
  logic    rxd;
  byte_t   rx_data;
  logic    rx_valid;
  logic    rx_ready;
  logic    frame_err;
  logic    overrun_err;
  logic    busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int frame_cyc = 0;
  int rise_cnt = 0, rise_cyc = 0, ferr_cnt = 0, ovr_cnt = 0;
  int base_rise, base_ferr, base_ovr;
  logic valid_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_i         (cfg),
    .rxd_i         (rxd),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .frame_err_o   (frame_err),
    .overrun_err_o (overrun_err),
    .busy_o        (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    valid_prev <= rx_valid;
    if (rx_valid && !valid_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun_err) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives start, nb data bits LSB first and ns stop bits; b = br_div+1.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] stopv,
                            input int ns, input int b);
    frame_cyc = cyc;
    rxd = 1'b0;
    repeat (16 * b) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rxd = d[i];
      repeat (16 * b) @(negedge clk);
    end
    for (int j = 0; j < ns; j++) begin
      rxd = stopv[j];
      repeat (16 * b) @(negedge clk);
    end
  endtask

  task automatic take_base();
    base_rise = rise_cnt;
    base_ferr = ferr_cnt;
    base_ovr  = ovr_cnt;
  endtask

  task automatic consume(input string tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check_eq(tag, 32'(rx_valid), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, 32'(rx_data), 32'h0);
    check_eq({tag, "_valid"}, 32'(rx_valid), 32'h0);
    check_eq({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check_eq({tag, "_ovr"}, 32'(overrun_err), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b0;
    cfg = '0;
    cfg.br_div = 16'd0;
    cfg.word = 1'b1;
    cfg.stop = 1'b0;
    cfg.en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1, B=1: valid at START entry + 153, START entry = drive + 3.
    take_base();
    send_frame(8'hA5, 8, 2'b01, 1, 1);
    repeat (4) @(negedge clk);
    check_eq("a5_rise", 32'(rise_cnt - base_rise), 32'd1);
    check_eq("a5_latency", 32'(rise_cyc - frame_cyc), 32'd156);
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
    check_eq("a5_ovr", 32'(ovr_cnt - base_ovr), 32'd0);
    consume("a5_consume");

    // 7-bit, 2 stop bits, B=4: (8+16*9)*4+1 = 609 after START entry.
    cfg.br_div = 16'd3;
    cfg.word = 1'b0;
    cfg.stop = 1'b1;
    take_base();
    send_frame(8'h7F, 7, 2'b11, 2, 4);
    repeat (4) @(negedge clk);
    check_eq("7f_rise", 32'(rise_cnt - base_rise), 32'd1);
    check_eq("7f_latency", 32'(rise_cyc - frame_cyc), 32'd612);
    check_eq("7f_data", 32'(rx_data), 32'h7F);
    consume("7f_consume");

    // Glitch: line low for 5 ticks (20 clocks at B=4) is a false start.
    take_base();
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("glitch_busy", 32'(busy), 32'h1);
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_idle", 32'(busy), 32'h0);
    check_eq("glitch_rise", 32'(rise_cnt - base_rise), 32'd0);
    check_eq("glitch_ferr", 32'(ferr_cnt - base_ferr), 32'd0);

    // Framing error: stop bit low, line then held low.
    cfg.br_div = 16'd0;
    cfg.word = 1'b1;
    cfg.stop = 1'b0;
    take_base();
    send_frame(8'h55, 8, 2'b00, 1, 1);
    repeat (20) @(negedge clk);
    check_eq("ferr_pulse", 32'(ferr_cnt - base_ferr), 32'd1);
    check_eq("ferr_wait", 32'(busy), 32'h1);
    check_eq("ferr_valid", 32'(rx_valid), 32'h0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("ferr_release", 32'(busy), 32'h0);

    // Overrun: two back-to-back frames, nothing consumed.
    take_base();
    send_frame(8'h11, 8, 2'b01, 1, 1);
    send_frame(8'h22, 8, 2'b01, 1, 1);
    repeat (4) @(negedge clk);
    check_eq("ovr_rise", 32'(rise_cnt - base_rise), 32'd1);
    check_eq("ovr_data", 32'(rx_data), 32'h11);
    check_eq("ovr_pulse", 32'(ovr_cnt - base_ovr), 32'd1);
    check_eq("ovr_valid", 32'(rx_valid), 32'h1);
    consume("ovr_consume");

    // Same-cycle accept: ready high only in the completion cycle (drive+155).
    take_base();
    send_frame(8'h11, 8, 2'b01, 1, 1);
    fork
      send_frame(8'h22, 8, 2'b01, 1, 1);
      begin
        repeat (155) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq("acc_data", 32'(rx_data), 32'h22);
        check_eq("acc_valid", 32'(rx_valid), 32'h1);
      end
    join
    repeat (4) @(negedge clk);
    check_eq("acc_ovr", 32'(ovr_cnt - base_ovr), 32'd0);
    check_eq("acc_hold", 32'(rx_valid), 32'h1);

    // Abort: en dropped during DATA.
    take_base();
    fork
      send_frame(8'h99, 8, 2'b01, 1, 1);
      begin
        repeat (60) @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'h1);
        cfg.en = 1'b0;
        @(negedge clk);
        check_eq("abort_idle", 32'(busy), 32'h0);
      end
    join
    cfg.en = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_rise", 32'(rise_cnt - base_rise), 32'd0);
    check_eq("abort_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
    check_eq("abort_ovr", 32'(ovr_cnt - base_ovr), 32'd0);
    check_eq("abort_data", 32'(rx_data), 32'h22);

    // Reset mid-frame, held until the line is idle again.
    fork
      send_frame(8'h5A, 8, 2'b01, 1, 1);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
      end
    join
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean frame after reset.
    take_base();
    send_frame(8'h3C, 8, 2'b01, 1, 1);
    repeat (4) @(negedge clk);
    check_eq("3c_rise", 32'(rise_cnt - base_rise), 32'd1);
    check_eq("3c_latency", 32'(rise_cyc - frame_cyc), 32'd156);
    check_eq("3c_data", 32'(rx_data), 32'h3C);
    check_eq("3c_ferr", 32'(ferr_cnt - base_ferr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
